fetch_sequencer: RTL

Instruction-fetch sequencer directly upstream of the control unit in the RISC-V core. It owns the program counter and fetches each instruction over a request/valid handshake to instruction memory. It holds the instruction stable for the datapath, where bits [6:0] drive the control unit opcode. It then selects the next PC from the control unit's Branch/Save_PC/PC_Select outputs and retires the instruction with a one-cycle commit strobe.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/next_pc_logic.sv | 27 ++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch sequencer state, reset defaults, opcodes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Base opcodes, instruction bits [6:0]
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_I_JALR = 7'b1100111;
    localparam logic [6:0] OPC_S_TYPE = 7'b0100011;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_U_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_J_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    // A fetch target must be word aligned
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC select and misaligned-target detection, purely combinational.
module next_pc_logic
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic            branch,
    input  logic            save_pc,
    input  logic            pc_select,
    input  logic            cond,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Priority: JALR target, then taken branch / jump, then sequential
    always_comb begin
        next_pc = pc_plus_4;
        if (pc_select) begin
            next_pc = {jalr_target[XLEN-1:1], 1'b0};
        end else if (branch && (save_pc || cond)) begin
            next_pc = branch_target;
        end
        misaligned = !is_word_aligned(next_pc);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/valid, retires with a commit strobe.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        Imem_Req_o,
    output logic [31:0] Imem_Addr_o,
    input  logic        Imem_Ready_i,
    input  logic        Imem_Valid_i,
    input  logic [31:0] Imem_Data_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic        Save_PC_i,
    input  logic        PC_Select_i,
    input  logic        Cond_i,
    input  logic [31:0] Branch_Target_i,
    input  logic [31:0] Jalr_Target_i,
    output logic [31:0] Instruction_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus_4_o,
    output logic        Instr_Valid_o,
    output logic        Commit_o,
    output logic        Fault_o,
    output logic [31:0] Retired_Count_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus_4_q, pc_plus_4_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_count_q, retired_count_d;
    logic         fault_q, fault_d;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         commit_c;

    // Next-PC candidate for the instruction currently held
    next_pc_logic u_next_pc (
        .pc_plus_4     (pc_plus_4_q),
        .branch        (Branch_i),
        .save_pc       (Save_PC_i),
        .pc_select     (PC_Select_i),
        .cond          (Cond_i),
        .branch_target (Branch_Target_i),
        .jalr_target   (Jalr_Target_i),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    assign commit_c = (state_q == ST_EXEC) && !Stall_i && !misaligned;

    // Next-state and next-register values; everything holds by default
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        retired_count_d = retired_count_q;
        fault_d         = fault_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (Imem_Ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Imem_Valid_i) begin
                    instr_d = Imem_Data_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!Stall_i) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d            = next_pc;
                        retired_count_d = retired_count_q + 32'd1;
                        instr_d         = NOP_WORD;
                        state_d         = ST_FETCH;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
        pc_plus_4_d = pc_d + 32'd4;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            pc_plus_4_q     <= RESET_PC + 32'd4;
            instr_q         <= NOP_WORD;
            retired_count_q <= 32'd0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_plus_4_q     <= pc_plus_4_d;
            instr_q         <= instr_d;
            retired_count_q <= retired_count_d;
            fault_q         <= fault_d;
        end
    end

    assign Imem_Req_o      = (state_q == ST_FETCH);
    assign Instr_Valid_o   = (state_q == ST_EXEC);
    assign Imem_Addr_o     = pc_q;
    assign PC_o            = pc_q;
    assign PC_Plus_4_o     = pc_plus_4_q;
    assign Instruction_o   = instr_q;
    assign Retired_Count_o = retired_count_q;
    assign Fault_o         = fault_q;
    assign Commit_o        = commit_c;

endmodule
